// File: rtl/imm_ctrl.sv
// imm_ctrl: sequences the constant/immediate extension unit.
// Takes decoded instruction words from decode, drives the extension unit's
// select (cs) and 6-bit immediate, then hands the final 8-bit constant to
// the register-write/ALU stage together with its destination and op tags.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. A producer holds valid and its payload stable until
// that transfer. in_ready depends only on state, never on in_valid.
module imm_ctrl #(
  parameter int CNT_W  = 8,
  parameter bit PFX_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  output logic             cs,
  output logic [5:0]       immediate,
  input  logic [7:0]       ext_immediate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_rd,
  output logic [1:0]       out_op,
  output logic [7:0]       out_data,
  output logic             pfx_pending,
  output logic             busy,
  output logic [CNT_W-1:0] drop_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXT  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_cs;
  logic [5:0]       r_imm;
  logic [2:0]       r_rd;
  logic [1:0]       r_op;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_pfx_pending;
  logic [1:0]       r_pfx_bits;
  logic [CNT_W-1:0] r_drop;

  logic [3:0]       w_opc;
  logic             w_is_imm;
  logic             w_is_pfx;
  logic [1:0]       w_op_code;
  logic             w_unused_bits;

  assign w_opc         = in_instr[15:12];
  assign w_is_pfx      = PFX_EN && (w_opc == 4'hF);
  // Bits [8:6] carry no meaning for this unit.
  assign w_unused_bits = &in_instr[8:6];

  // Classify the incoming opcode and pick its output op tag.
  always_comb begin
    w_is_imm  = 1'b0;
    w_op_code = 2'b00;
    case (w_opc)
      4'h1: begin w_is_imm = 1'b1; w_op_code = 2'b00; end  // LDI
      4'h2: begin w_is_imm = 1'b1; w_op_code = 2'b01; end  // LDIU
      4'h3: begin w_is_imm = 1'b1; w_op_code = 2'b10; end  // ADDI
      default: begin w_is_imm = 1'b0; w_op_code = 2'b00; end
    endcase
  end

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cs          <= 1'b0;
      r_imm         <= 6'd0;
      r_rd          <= 3'd0;
      r_op          <= 2'b00;
      r_data        <= 8'd0;
      r_valid       <= 1'b0;
      r_pfx_pending <= 1'b0;
      r_pfx_bits    <= 2'b00;
      r_drop        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (w_is_imm) begin
              r_rd    <= in_instr[11:9];
              r_op    <= w_op_code;
              r_imm   <= in_instr[5:0];
              // Only LDIU zero-extends; LDI and ADDI are signed.
              r_cs    <= (w_opc != 4'h2);
              r_state <= ST_EXT;
            end else if (w_is_pfx) begin
              // A later prefix simply replaces an earlier one.
              r_pfx_bits    <= in_instr[1:0];
              r_pfx_pending <= 1'b1;
            end else begin
              // Unknown opcodes are consumed, counted and kill any prefix.
              r_drop        <= r_drop + LP_CNT_ONE;
              r_pfx_pending <= 1'b0;
            end
          end
        end
        ST_EXT: begin
          // One cycle lets the combinational extension unit settle on
          // the registered cs/immediate before we sample it.
          r_data        <= r_pfx_pending ? {r_pfx_bits, r_imm} : ext_immediate;
          r_pfx_pending <= 1'b0;
          r_valid       <= 1'b1;
          r_state       <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign dbg_state   = r_state;
  assign cs          = r_cs;
  assign immediate   = r_imm;
  assign out_valid   = r_valid;
  assign out_rd      = r_rd;
  assign out_op      = r_op;
  assign out_data    = r_data;
  assign pfx_pending = r_pfx_pending;
  assign drop_count  = r_drop;

endmodule
